mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_array.sv | 34 +++
 rtl/mem_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states, word geometry
// and the default placement of word 0 in the byte address space.
package mem_pkg;

    localparam int WORD_W = 64;
    localparam int MASK_W = WORD_W / 8;

    localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage with per-byte write enables and a registered
// read port. Contents are deliberately not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [MASK_W-1:0] wmask,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Byte-masked write and registered read share the single address port
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wmask[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one load/store at a time, waits LATENCY cycles,
// performs the storage access on the edge entering RESP and holds the
// response until the core takes it.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [63:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int         AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t            state;
    logic [3:0]        count;
    logic              lat_write;
    logic              lat_err;
    logic [AW-1:0]     lat_idx;
    logic [WORD_W-1:0] lat_wdata;
    logic [MASK_W-1:0] lat_wmask;
    logic              rdata_sel;
    logic [WORD_W-1:0] mem_rdata;

    logic [63:0]       offset;
    logic [63:0]       word_off;
    logic              req_err;
    logic [AW-1:0]     req_idx;
    logic              accept;
    logic              enter_resp;
    logic              cur_write;
    logic              cur_err;
    logic [AW-1:0]     cur_idx;
    logic [WORD_W-1:0] cur_wdata;
    logic [MASK_W-1:0] cur_wmask;
    logic              mem_we;
    logic              mem_re;

    // Decode the incoming address; addresses below the base never wrap in
    always_comb begin
        offset   = req_addr - BASE_ADDR;
        word_off = offset >> 3;
        req_err  = (req_addr < BASE_ADDR) || (word_off >= 64'(DEPTH));
        req_idx  = word_off[AW-1:0];
    end

    // Zero latency must use the live request, otherwise the latched copy
    always_comb begin
        accept     = rst && req_valid && req_ready;
        enter_resp = (accept && (LAT == 4'd0)) ||
                     (rst && (state == WAIT) && (count == 4'd1));
        if (state == IDLE) begin
            cur_write = req_write;
            cur_err   = req_err;
            cur_idx   = req_idx;
            cur_wdata = req_wdata;
            cur_wmask = req_wmask;
        end else begin
            cur_write = lat_write;
            cur_err   = lat_err;
            cur_idx   = lat_idx;
            cur_wdata = lat_wdata;
            cur_wmask = lat_wmask;
        end
        mem_we = enter_resp && cur_write && !cur_err;
        mem_re = enter_resp && !cur_write && !cur_err;
    end

    // Request/response FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata_sel  <= 1'b0;
            lat_write  <= 1'b0;
            lat_err    <= 1'b0;
            lat_idx    <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_err   <= req_err;
                        lat_idx   <= req_idx;
                        lat_wdata <= req_wdata;
                        lat_wmask <= req_wmask;
                        req_ready <= 1'b0;
                        if (LAT == 4'd0) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= req_err;
                            rdata_sel  <= !req_write && !req_err;
                        end else begin
                            state <= WAIT;
                            count <= LAT;
                        end
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= lat_err;
                        rdata_sel  <= !lat_write && !lat_err;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        rdata_sel  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign resp_rdata = rdata_sel ? mem_rdata : '0;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .wmask (cur_wmask),
        .rdata (mem_rdata)
    );

endmodule
